// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
// Holds the architectural HI/LO registers. MTHI/MTLO write them while the unit is idle.
// Results for MULT/MULTU/DIV/DIVU are computed on operand magnitudes:
//   - multiply uses one shift-add step per cycle;
//   - divide uses one restoring step per cycle;
//   - a FIX state then applies the sign correction.
// The WB state presents the result on hi/lo together with the done pulse.
// Optional build macro: MULDIV_FAST_MUL_EN.
//   When defined, MULT/MULTU use a single registered 32x32 multiply, so done arrives
//   two edges after start. Divides keep the full 34-edge latency.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [4:0]        r_cnt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_res;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_accept;
  logic              w_signed;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_rem_sh;
  logic              w_rem_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_step;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [2*XLEN-1:0] w_fix;

  // op[0]==0 selects the signed variants (MULT, DIV).
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && op1[XLEN-1]) ? (-op1) : op1;
  assign w_b_mag  = (w_signed && op2[XLEN-1]) ? (-op2) : op2;

  // Multiply step, MSB first: acc = 2*acc + (b[cnt] ? a : 0).
  assign w_mul_step = {r_acc[2*XLEN-2:0], 1'b0} +
                      (r_b[r_cnt] ? {{XLEN{1'b0}}, r_a} : {(2*XLEN){1'b0}});

  // Restoring divide step: the remainder lives in acc[63:32].
  // The quotient shifts into acc[31:0].
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_a[r_cnt]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_b;
  assign w_div_step = {(w_rem_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_rem_ge};

  assign w_quo = r_acc[XLEN-1:0];
  assign w_rem = r_acc[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_prod;
  assign w_prod = {{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, r_b};
`endif

  // Sign correction and the divide-by-zero override of the raw magnitude result.
  always_comb begin
    w_fix = r_acc;
    case (r_op)
      2'b00: w_fix = r_neg_q ? (-r_acc) : r_acc;
      2'b01: w_fix = r_acc;
      2'b10, 2'b11: begin
        if (r_dz) begin
          w_fix = {r_op1, {XLEN{1'b1}}};
        end else begin
          w_fix = {(r_neg_r ? (-w_rem) : w_rem), (r_neg_q ? (-w_quo) : w_quo)};
        end
      end
      default: w_fix = r_acc;
    endcase
  end

  // Next-state logic for IDLE -> CALC -> FIX -> WB (fast multiply skips FIX).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CALC;
        else       w_state_nxt = S_IDLE;
      end
      S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
        if (!r_op[1])           w_state_nxt = S_WB;
        else if (r_cnt == 5'd0) w_state_nxt = S_FIX;
        else                    w_state_nxt = S_CALC;
`else
        if (r_cnt == 5'd0) w_state_nxt = S_FIX;
        else               w_state_nxt = S_CALC;
`endif
      end
      S_FIX:   w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control and architectural state: FSM, handshake outputs, sticky flag, HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= {XLEN{1'b0}};
      r_lo       <= {XLEN{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_WB);
      if (w_accept) begin
        r_div_zero <= 1'b0;
      end else if (r_state == S_WB) begin
        r_div_zero <= r_dz;
      end
      if (r_state == S_WB) begin
        r_hi <= r_res[2*XLEN-1:XLEN];
        r_lo <= r_res[XLEN-1:0];
      end else if ((r_state == S_IDLE) && !start) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  // Datapath: latch operands at accept, iterate in CALC, correct signs in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 5'd0;
      r_op    <= 2'b00;
      r_op1   <= {XLEN{1'b0}};
      r_a     <= {XLEN{1'b0}};
      r_b     <= {XLEN{1'b0}};
      r_acc   <= {(2*XLEN){1'b0}};
      r_res   <= {(2*XLEN){1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_op1   <= op1;
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg_q <= w_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
            r_neg_r <= w_signed && op1[XLEN-1];
            r_dz    <= op[1] && (op2 == {XLEN{1'b0}});
            r_acc   <= {(2*XLEN){1'b0}};
            r_cnt   <= 5'd31;
          end
        end
        S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
          if (!r_op[1]) begin
            r_res <= r_neg_q ? (-w_prod) : w_prod;
          end else begin
            r_acc <= w_div_step;
            r_cnt <= r_cnt - 5'd1;
          end
`else
          r_acc <= r_op[1] ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - 5'd1;
`endif
        end
        S_FIX:   r_res <= w_fix;
        default: r_res <= r_res;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit with hand-written handshake sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_bad;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1), .op2(op2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 34 : 2;
`else
    return 34;
`endif
  endfunction

  // Launch one operation and wait (bounded) for done; latency is counted in edges after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int got_lat, output logic dz_at_start);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    dz_at_start = div_zero;
    start = 1'b0; op1 = $urandom; op2 = $urandom;
    got_lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        got_lat = k;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic dzs;
    int   done_seen;

    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b1; op = 2'b00; op1 = 32'd9; op2 = 32'd9;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[11] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    // Reset held for two edges with start asserted.
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dz", {31'd0, div_zero}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // MTHI/MTLO in IDLE, both at once, then HI alone.
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00001234;
    @(posedge clk); #1;
    chk("mt_both_hi", hi, 32'h00001234);
    chk("mt_both_lo", lo, 32'h00001234);
    @(negedge clk); lo_we = 1'b0; wdata = 32'h0000ABCD;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h0000ABCD);
    chk("mthi_lo", lo, 32'h00001234);
    @(negedge clk); hi_we = 1'b0;

    // Table of operations, launched back to back.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, dzs);
      chk($sformatf("v%0d_dz_clear_at_start", i), {31'd0, dzs}, 32'd0);
      chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].op));
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
    end

    // Collisions: MTHI with the accepted start, a second start at N+5, and MTHI at N+10.
    @(negedge clk);
    start = 1'b1; op = 2'b11; op1 = 32'd100; op2 = 32'd7; hi_we = 1'b1; wdata = 32'h0000DEAD;
    @(posedge clk); #1;
    chk("coll_busy_n", {31'd0, busy}, 32'd0);
    start = 1'b0; hi_we = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1; op = 2'b00; op1 = 32'd9; op2 = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (k == 10) begin
        hi_we = 1'b1; wdata = 32'h0000DEAD;
      end else begin
        hi_we = 1'b0;
      end
      @(posedge clk); #1;
      if (k == 1)  chk("coll_busy_n1", {31'd0, busy}, 32'd1);
      if (k == 33) chk("coll_busy_n33", {31'd0, busy}, 32'd1);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    chk("coll_latency", lat, 32'd34);
    chk("coll_hi", hi, 32'd2);
    chk("coll_lo", lo, 32'd14);

    // Abort DIVU 100/7 with reset at N+20, then rerun it.
    @(negedge clk);
    start = 1'b1; op = 2'b11; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rst = (k == 20);
      @(posedge clk); #1;
    end
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    run_op(2'b11, 32'd100, 32'd7, lat, dzs);
    chk("rerun_latency", lat, 32'd34);
    chk("rerun_hi", hi, 32'd2);
    chk("rerun_lo", lo, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
